alu_seq: RTL and testbench



---
 rtl/alu_seq_pkg.sv | 32 +++
 rtl/alu_comb.sv | 68 ++++++
 rtl/alu_seq.sv | 166 ++++++++++++++++
 tb/tb_alu_seq.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: opcode mnemonics, FSM states and
// opcode classification helpers.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        ADD  = 4'd0,
        LSH  = 4'd1,
        RSH  = 4'd2,
        XOR  = 4'd3,
        AND  = 4'd4,
        SUB  = 4'd5,
        CLR  = 4'd6,
        XORA = 4'd7,
        ADC  = 4'd8,
        SBB  = 4'd9,
        LSHN = 4'd10,
        RSHN = 4'd11,
        ROL  = 4'd12,
        ROR  = 4'd13
    } op_mne;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } alu_state_e;

    // Variable-distance ops that take one cycle per bit of distance.
    function automatic logic is_n_op(input logic [3:0] op);
        return (op == LSHN) || (op == RSHN) || (op == ROL) || (op == ROR);
    endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle combinational datapath. Variable-distance ops return InA with
// carry passed through, which is exactly the N==0 result.
module alu_comb
    import alu_seq_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [3:0]   i_op,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_res,
    output logic         o_cout,
    output logic         o_illegal
);

    logic [W:0] w_wide;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        o_res     = i_a;
        o_cout    = i_cin;
        o_illegal = 1'b0;
        w_wide    = '0;
        case (i_op)
            ADD: begin
                w_wide = {1'b0, i_a} + {1'b0, i_b};
                {o_cout, o_res} = w_wide;
            end
            ADC: begin
                w_wide = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_cin};
                {o_cout, o_res} = w_wide;
            end
            SUB: begin
                w_wide = {1'b0, i_a} - {1'b0, i_b};
                o_res  = w_wide[W-1:0];
                o_cout = ~w_wide[W];
            end
            SBB: begin
                // Carry is an active-high "no borrow", so the borrow-in is ~Carry.
                w_wide = {1'b0, i_a} - {1'b0, i_b} - {{W{1'b0}}, ~i_cin};
                o_res  = w_wide[W-1:0];
                o_cout = ~w_wide[W];
            end
            LSH: begin
                o_res  = {i_a[W-2:0], i_cin};
                o_cout = i_a[W-1];
            end
            RSH: begin
                o_res  = {i_cin, i_a[W-1:1]};
                o_cout = i_a[0];
            end
            XOR:  o_res = i_a ^ i_b;
            AND:  o_res = i_a & i_b;
            CLR: begin
                o_res  = '0;
                o_cout = 1'b0;
            end
            XORA: o_res = {{(W-1){1'b0}}, ^i_a};
            LSHN, RSHN, ROL, ROR: begin
                o_res  = i_a;
                o_cout = i_cin;
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU top: single-cycle ops complete in one edge, variable shifts
// and rotates step one bit per edge under a Start/Busy/Done handshake.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic [3:0]   Op,
    input  logic [W-1:0] InA,
    input  logic [W-1:0] InB,
    output logic         Busy,
    output logic         Done,
    output logic [W-1:0] Out,
    output logic         Carry,
    output logic         Zero,
    output logic         Parity,
    output logic         Illegal
);

    localparam int CW = $clog2(W);

    alu_state_e    r_state;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_op;
    logic [W-1:0]  r_work;
    logic          r_work_c;
    logic [W-1:0]  r_out;
    logic          r_carry;
    logic          r_zero;
    logic          r_parity;
    logic          r_illegal;
    logic          r_busy;
    logic          r_done;

    logic [CW-1:0] w_n;
    logic [W-1:0]  w_res;
    logic          w_cout;
    logic          w_illegal;
    logic          w_in_shift;
    logic [3:0]    w_step_op;
    logic [W-1:0]  w_step_v;
    logic          w_step_c;
    logic [W-1:0]  w_next_v;
    logic          w_next_c;
    logic          w_fin;
    logic          w_enter;
    logic [W-1:0]  w_fin_v;
    logic          w_fin_c;
    logic          w_fin_ill;

    assign w_n = InB[CW-1:0];

    alu_comb #(.W(W)) u_comb (
        .i_op      (Op),
        .i_a       (InA),
        .i_b       (InB),
        .i_cin     (r_carry),
        .o_res     (w_res),
        .o_cout    (w_cout),
        .o_illegal (w_illegal)
    );

    // The first bit of a multi-cycle op is taken on the Start edge itself, so
    // the total latency equals the distance N.
    assign w_in_shift = (r_state == SHIFT);
    assign w_step_op  = w_in_shift ? r_op     : Op;
    assign w_step_v   = w_in_shift ? r_work   : InA;
    assign w_step_c   = w_in_shift ? r_work_c : r_carry;

    always_comb begin
        w_next_v = w_step_v;
        w_next_c = w_step_c;
        case (w_step_op)
            LSHN:    {w_next_c, w_next_v} = {w_step_v[W-1], w_step_v[W-2:0], 1'b0};
            RSHN:    {w_next_v, w_next_c} = {1'b0, w_step_v[W-1:1], w_step_v[0]};
            ROL:     w_next_v = {w_step_v[W-2:0], w_step_v[W-1]};
            ROR:     w_next_v = {w_step_v[0], w_step_v[W-1:1]};
            default: ;
        endcase
    end

    always_comb begin
        w_fin     = 1'b0;
        w_enter   = 1'b0;
        w_fin_v   = r_out;
        w_fin_c   = r_carry;
        w_fin_ill = 1'b0;
        if (w_in_shift) begin
            if (r_cnt == CW'(1)) begin
                w_fin   = 1'b1;
                w_fin_v = w_next_v;
                w_fin_c = w_next_c;
            end
        end else if (Start) begin
            if (is_n_op(Op) && (w_n > CW'(1))) begin
                w_enter = 1'b1;
            end else if (is_n_op(Op) && (w_n == CW'(1))) begin
                w_fin   = 1'b1;
                w_fin_v = w_next_v;
                w_fin_c = w_next_c;
            end else if (w_illegal) begin
                w_fin     = 1'b1;
                w_fin_ill = 1'b1;
            end else begin
                w_fin   = 1'b1;
                w_fin_v = w_res;
                w_fin_c = w_cout;
            end
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; the synchronous reset covers every register here.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_op      <= '0;
            r_work    <= '0;
            r_work_c  <= 1'b0;
            r_out     <= '0;
            r_carry   <= 1'b0;
            r_zero    <= 1'b0;
            r_parity  <= 1'b0;
            r_illegal <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_fin;
            if (w_enter) begin
                r_state  <= SHIFT;
                r_busy   <= 1'b1;
                r_op     <= Op;
                r_work   <= w_next_v;
                r_work_c <= w_next_c;
                r_cnt    <= w_n - CW'(1);
            end else if (w_in_shift && !w_fin) begin
                r_work   <= w_next_v;
                r_work_c <= w_next_c;
                r_cnt    <= r_cnt - CW'(1);
            end
            if (w_fin) begin
                r_state   <= IDLE;
                r_busy    <= 1'b0;
                r_cnt     <= '0;
                r_out     <= w_fin_v;
                r_carry   <= w_fin_c;
                r_zero    <= ~|w_fin_v;
                r_parity  <= ^w_fin_v;
                r_illegal <= w_fin_ill;
            end
        end
    end

    assign Busy    = r_busy;
    assign Done    = r_done;
    assign Out     = r_out;
    assign Carry   = r_carry;
    assign Zero    = r_zero;
    assign Parity  = r_parity;
    assign Illegal = r_illegal;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vector table, hand-written reset
// sequences and randomized ops against an arithmetic reference model.
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int W    = 8;
    localparam int MASK = (1 << W) - 1;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         Start;
    logic [3:0]   Op;
    logic [W-1:0] InA;
    logic [W-1:0] InB;
    logic         Busy;
    logic         Done;
    logic [W-1:0] Out;
    logic         Carry;
    logic         Zero;
    logic         Parity;
    logic         Illegal;

    int n_vec  = 0;
    int n_miss = 0;
    int m_out   = 0;
    int m_carry = 0;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        bit           poke;
        logic [W-1:0] out;
        logic         c;
        logic         z;
        logic         p;
        logic         ill;
        int           lat;
    } vec_t;

    vec_t tbl[$];

    always #5 Clk = ~Clk;

    alu_seq #(.W(W)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Start   (Start),
        .Op      (Op),
        .InA     (InA),
        .InB     (InB),
        .Busy    (Busy),
        .Done    (Done),
        .Out     (Out),
        .Carry   (Carry),
        .Zero    (Zero),
        .Parity  (Parity),
        .Illegal (Illegal)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: the operation rules expressed as plain integer arithmetic.
    task automatic ref_op(input int op, input int a, input int b,
                          output int eo, output int ec, output int eill, output int elat);
        int n, s, bor;
        n    = b % W;
        eo   = m_out;
        ec   = m_carry;
        eill = 0;
        elat = 1;
        case (op)
            0:  begin s = a + b;           eo = s & MASK; ec = (s >> W) & 1; end
            8:  begin s = a + b + m_carry; eo = s & MASK; ec = (s >> W) & 1; end
            5:  begin eo = (a - b) & MASK; ec = (a >= b) ? 1 : 0; end
            9:  begin
                bor = 1 - m_carry;
                eo  = (a - b - bor) & MASK;
                ec  = (a >= b + bor) ? 1 : 0;
            end
            1:  begin eo = ((a << 1) | m_carry) & MASK; ec = (a >> (W - 1)) & 1; end
            2:  begin eo = (m_carry << (W - 1)) | (a >> 1); ec = a & 1; end
            3:  eo = a ^ b;
            4:  eo = a & b;
            6:  begin eo = 0; ec = 0; end
            7:  eo = $countones(a) & 1;
            10: begin eo = (a << n) & MASK; if (n > 0) ec = (a >> (W - n)) & 1; end
            11: begin eo = a >> n; if (n > 0) ec = (a >> (n - 1)) & 1; end
            12: eo = ((a << n) | (a >> (W - n))) & MASK;
            13: eo = ((a >> n) | (a << (W - n))) & MASK;
            default: eill = 1;
        endcase
        if (op >= 10 && op <= 13 && n > 0) elat = n;
        m_out   = eo;
        m_carry = ec;
    endtask

    // Called at a negedge; returns at the negedge of the Done cycle with Start low.
    task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit poke, output int lat, output logic [W-1:0] o,
                         output logic c, output logic z, output logic p, output logic ill);
        Start = 1'b1;
        Op    = op;
        InA   = a;
        InB   = b;
        lat   = 0;
        forever begin
            @(negedge Clk);
            lat++;
            if (Done === 1'b1) begin
                Start = 1'b0;
                check("busy_at_done", {31'd0, Busy}, 0);
                break;
            end
            check("busy_in_flight", {31'd0, Busy}, 1);
            Start = poke;
            Op    = CLR;
            if (lat >= 3 * W) begin
                n_vec++;
                n_miss++;
                $display("FAIL timeout: no Done after %0d cycles, expected within %0d", lat, W);
                Start = 1'b0;
                break;
            end
        end
        o   = Out;
        c   = Carry;
        z   = Zero;
        p   = Parity;
        ill = Illegal;
    endtask

    task automatic run_vec(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input bit poke, input int eo, input int ec,
                           input int eill, input int elat);
        int lat;
        logic [W-1:0] o;
        logic c, z, p, ill;
        do_op(op, a, b, poke, lat, o, c, z, p, ill);
        check({tag, "_lat"},     lat, elat);
        check({tag, "_out"},     {24'd0, o}, eo);
        check({tag, "_carry"},   {31'd0, c}, ec);
        check({tag, "_zero"},    {31'd0, z}, (eo == 0) ? 1 : 0);
        check({tag, "_parity"},  {31'd0, p}, $countones(eo) & 1);
        check({tag, "_illegal"}, {31'd0, ill}, eill);
    endtask

    task automatic check_all_reset(input string tag);
        check({tag, "_out"},     {24'd0, Out}, 0);
        check({tag, "_carry"},   {31'd0, Carry}, 0);
        check({tag, "_zero"},    {31'd0, Zero}, 0);
        check({tag, "_parity"},  {31'd0, Parity}, 0);
        check({tag, "_illegal"}, {31'd0, Illegal}, 0);
        check({tag, "_busy"},    {31'd0, Busy}, 0);
        check({tag, "_done"},    {31'd0, Done}, 0);
    endtask

    initial begin
        int eo, ec, eill, elat;
        logic [3:0] rop;
        logic [W-1:0] ra, rb;

        //            op     a      b      poke  out    c  z  p  ill lat
        tbl.push_back('{ADD,  8'hF0, 8'h20, 1'b0, 8'h10, 1, 0, 1, 0, 1});
        tbl.push_back('{ADC,  8'h01, 8'h01, 1'b0, 8'h03, 0, 0, 0, 0, 1});
        tbl.push_back('{SUB,  8'h05, 8'h05, 1'b0, 8'h00, 1, 1, 0, 0, 1});
        tbl.push_back('{SUB,  8'h03, 8'h05, 1'b0, 8'hFE, 0, 0, 1, 0, 1});
        tbl.push_back('{LSHN, 8'h81, 8'h03, 1'b1, 8'h08, 0, 0, 1, 0, 3});
        tbl.push_back('{ROR,  8'h01, 8'h09, 1'b0, 8'h80, 0, 0, 1, 0, 1});
        tbl.push_back('{ROL,  8'h5A, 8'h00, 1'b0, 8'h5A, 0, 0, 0, 0, 1});
        tbl.push_back('{RSHN, 8'h01, 8'h01, 1'b0, 8'h00, 1, 1, 0, 0, 1});
        tbl.push_back('{LSH,  8'h80, 8'h00, 1'b0, 8'h01, 1, 0, 1, 0, 1});
        tbl.push_back('{RSH,  8'h02, 8'h00, 1'b0, 8'h81, 0, 0, 0, 0, 1});
        tbl.push_back('{ADD,  8'h10, 8'h00, 1'b0, 8'h10, 0, 0, 1, 0, 1});
        tbl.push_back('{4'hE, 8'h55, 8'h55, 1'b0, 8'h10, 0, 0, 1, 1, 1});
        tbl.push_back('{AND,  8'hFF, 8'h00, 1'b0, 8'h00, 0, 1, 0, 0, 1});
        tbl.push_back('{XORA, 8'h07, 8'h00, 1'b0, 8'h01, 0, 0, 1, 0, 1});
        tbl.push_back('{SUB,  8'h00, 8'h01, 1'b0, 8'hFF, 0, 0, 0, 0, 1});
        tbl.push_back('{SBB,  8'h05, 8'h02, 1'b0, 8'h02, 1, 0, 1, 0, 1});
        tbl.push_back('{ADC,  8'hFF, 8'h00, 1'b0, 8'h00, 1, 1, 0, 0, 1});
        tbl.push_back('{LSHN, 8'hFF, 8'h00, 1'b0, 8'hFF, 1, 0, 0, 0, 1});
        tbl.push_back('{ROL,  8'h81, 8'h01, 1'b0, 8'h03, 1, 0, 0, 0, 1});
        tbl.push_back('{CLR,  8'h12, 8'h34, 1'b0, 8'h00, 0, 1, 0, 0, 1});
        tbl.push_back('{RSHN, 8'h80, 8'h07, 1'b0, 8'h01, 0, 0, 1, 0, 7});
        tbl.push_back('{XOR,  8'hA5, 8'hFF, 1'b0, 8'h5A, 0, 0, 0, 0, 1});

        Reset = 1'b1;
        Start = 1'b0;
        Op    = '0;
        InA   = '0;
        InB   = '0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check_all_reset("reset");
        Reset = 1'b0;

        foreach (tbl[i]) begin
            ref_op(int'(tbl[i].op), int'(tbl[i].a), int'(tbl[i].b), eo, ec, eill, elat);
            run_vec($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].poke,
                    int'(tbl[i].out), int'(tbl[i].c), int'(tbl[i].ill), tbl[i].lat);
        end

        // Done is a single-cycle pulse and the result holds afterwards.
        @(negedge Clk);
        check("done_pulse", {31'd0, Done}, 0);
        check("out_held", {24'd0, Out}, 32'h5A);

        // Reset while a rotate is in flight aborts it with no Done.
        Start = 1'b1; Op = ROL; InA = 8'h01; InB = 8'h07;
        @(negedge Clk);
        Start = 1'b0;
        check("abort_busy", {31'd0, Busy}, 1);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        check_all_reset("abort");
        @(negedge Clk);
        check("abort_no_done", {31'd0, Done}, 0);
        check("abort_idle", {31'd0, Busy}, 0);
        m_out = 0; m_carry = 0;
        ref_op(int'(XORA), 8'h07, 0, eo, ec, eill, elat);
        run_vec("post_abort_xora", XORA, 8'h07, 8'h00, 1'b0, 1, 0, 0, 1);

        // Reset and Start on the same edge: reset wins.
        Reset = 1'b1; Start = 1'b1; Op = ADD; InA = 8'hFF; InB = 8'hFF;
        @(negedge Clk);
        Reset = 1'b0; Start = 1'b0;
        check_all_reset("reset_vs_start");
        m_out = 0; m_carry = 0;

        for (int i = 0; i < 300; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = W'($urandom);
            rb  = W'($urandom);
            ref_op(int'(rop), int'(ra), int'(rb), eo, ec, eill, elat);
            run_vec($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb, 1'($urandom), eo, ec, eill, elat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
